line_fill_reader: RTL and testbench
===================================

# line_fill_reader

Read-side counterpart to the cache's store-merge path. It fetches a 256-bit cache line from physical memory as four 64-bit bursts, assembles the line in a local buffer, and returns both the full line (for the data array) and the 32-bit word selected by address bits [4:2] (for the CPU). It sits between the cache controller's miss handling and the physical-memory port.

## Interface
- BURST_WIDTH, 64, bits per memory burst; BURST_WIDTH × NUM_BURSTS must equal 256.
- NUM_BURSTS, 4, bursts per line; the counter width is $clog2(NUM_BURSTS).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- req_read  in  1  fill request; held high until resp.
- req_addr  in  32 (rv32i_word)  requested byte address; sampled only when a request is accepted.
- resp  out  1  one-cycle pulse; line and word are valid.
- word_valid  out  1  requested word valid (see Configuration).
- resp_rdata  out  32 (rv32i_word)  selected word, equal to line[32*addr[4:2] +: 32].
- resp_line  out  256  assembled line; burst k occupies bits [64k+63:64k].
- pmem_read  out  1  memory read request.
- pmem_address  out  32  line-aligned address, {addr[31:5], 5'b0}.
- pmem_resp  in  1  burst valid strobe; one burst per cycle while high.
- pmem_rdata  in  64  burst data.

## Operation
- The FSM has three states: IDLE, FILL, DONE.
- IDLE
  - When req_read=1, latch req_addr into addr_q, clear the burst counter and the line buffer, and go to FILL.
  - Otherwise stay in IDLE.
- FILL
  - pmem_read=1 (decoded from state).
  - On each cycle with pmem_resp=1, write pmem_rdata into buffer slot cnt, then cnt++.
  - When pmem_resp=1 and cnt=NUM_BURSTS-1, go to DONE.
  - Cycles with pmem_resp=0 are stalls: hold state and counter.
- DONE
  - resp=1 for exactly one cycle; resp_line and resp_rdata are driven from the buffer.
  - Go to IDLE unconditionally.
- The word select uses addr_q[4:2]. Bits [1:0] are ignored, so whole words are always returned.
- Boundary conditions:
  - pmem_resp in IDLE or DONE is ignored; the buffer is unchanged.
  - Changes on req_addr during FILL or DONE are ignored; addr_q is used.
  - If req_read is still high in the IDLE cycle after resp, it is a new request and starts a back-to-back fill. Requesters must drop req_read by then if no new fill is wanted.
  - The counter never wraps inside a fill; it is cleared on every accept.
  - rst mid-FILL: the next cycle is IDLE with cnt=0, pmem_read=0 and the buffer cleared. Any in-flight bursts are then ignored.

## Timing
- Reset values: state IDLE, cnt 0, buffer 0, addr_q 0.
- Outputs after reset: resp 0, word_valid 0, pmem_read 0, pmem_address 0, resp_rdata 0, resp_line 0.
- Accept in cycle 0: pmem_read is high from cycle 1.
- With no stalls, bursts land in cycles 1–4, DONE/resp is in cycle 5, and pmem_read is low again in cycle 5.
- Minimum request-to-resp latency is 5 cycles; each stall cycle adds 1.
- resp_line and resp_rdata hold their values until the next accept. They are guaranteed valid only while resp=1 or word_valid=1.
- The next accept is possible in cycle 6, giving a 6-cycle minimum period.

## Configuration
- LFR_CRITICAL_WORD_EN defined:
  - word_valid pulses for one cycle in the cycle after the burst containing the requested word is written, i.e. burst index addr_q[4:3].
  - resp_rdata is valid from that cycle onward.
  - resp still waits for the full line.
- LFR_CRITICAL_WORD_EN undefined:
  - word_valid is identical to resp; no early forwarding.

## Test plan
- Reset, then idle: all outputs 0, and pmem_resp=1 with random data leaves resp_line=0.
- Read of req_addr=0x0000_1234 with bursts 0x1111…/0x2222…/0x3333…/0x4444…, no stalls:
  - pmem_address=0x0000_1220.
  - resp in cycle 5.
  - resp_rdata = word 5 = upper half of burst 2 = 0x33333333.
  - resp_line = {B3,B2,B1,B0}.
- Same read with pmem_resp low for 2 cycles between bursts 1 and 2: resp in cycle 7, data unchanged.
- Back-to-back reads 0x40, then 0x7C (req_read held): second fill accepted in the IDLE cycle after resp, and resp_rdata = burst 3 [63:32].
- rst asserted after 2 bursts: pmem_read=0 next cycle, no resp; a new read of 0x100 then completes correctly.
- With LFR_CRITICAL_WORD_EN, read 0x08: word_valid in cycle 3 (after burst 1), resp in cycle 5. Without the macro, word_valid appears only in cycle 5.

Source files
------------

// File: rtl/line_fill_reader.sv
// Fills one 256-bit cache line from four 64-bit memory bursts and returns the line plus the addressed word.
// Optional early forwarding of the requested word is enabled by defining LFR_CRITICAL_WORD_EN.
module line_fill_reader #(
  parameter int BURST_WIDTH = 64,
  parameter int NUM_BURSTS  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_read,
  input  logic [31:0]  req_addr,
  output logic         resp,
  output logic         word_valid,
  output logic [31:0]  resp_rdata,
  output logic [255:0] resp_line,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic         pmem_resp,
  input  logic [63:0]  pmem_rdata
);

  localparam int CNT_W = $clog2(NUM_BURSTS);
  localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(NUM_BURSTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_e;

  state_e                                 state_q, state_d;
  logic [CNT_W-1:0]                       burstCnt_q, burstCnt_d;
  logic [31:0]                            addr_q, addr_d;
  logic [NUM_BURSTS-1:0][BURST_WIDTH-1:0] lineBuf_q, lineBuf_d;
  logic                                   accept;
  logic                                   burstWe;
  logic [7:0][31:0]                       lineWords;
  logic [1:0]                             unused_addr_bits;

  assign accept  = (state_q == IDLE) && req_read;
  assign burstWe = (state_q == FILL) && pmem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      burstCnt_q <= '0;
      addr_q     <= '0;
      lineBuf_q  <= '0;
    end else begin
      state_q    <= state_d;
      burstCnt_q <= burstCnt_d;
      addr_q     <= addr_d;
      lineBuf_q  <= lineBuf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_read) state_d = FILL;
      FILL:    if (pmem_resp && (burstCnt_q == LAST_BURST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every accept starts from an empty buffer so stale words from the previous line never leak out.
  always_comb begin
    burstCnt_d = burstCnt_q;
    addr_d     = addr_q;
    lineBuf_d  = lineBuf_q;
    if (accept) begin
      addr_d     = req_addr;
      burstCnt_d = '0;
      lineBuf_d  = '0;
    end else if (burstWe) begin
      lineBuf_d[burstCnt_q] = pmem_rdata;
      if (burstCnt_q != LAST_BURST) begin
        burstCnt_d = burstCnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pmem_read = (state_q == FILL);
    resp      = (state_q == DONE);
  end

  assign pmem_address     = {addr_q[31:5], 5'b0};
  assign lineWords        = lineBuf_q;
  assign resp_rdata       = lineWords[addr_q[4:2]];
  assign resp_line        = lineBuf_q;
  assign unused_addr_bits = addr_q[1:0];

`ifdef LFR_CRITICAL_WORD_EN
  // The flag rises the cycle after the burst holding the requested word lands in the buffer.
  logic wordValid_q, wordValid_d;

  assign wordValid_d = burstWe && (burstCnt_q == addr_q[4:3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wordValid_q <= 1'b0;
    end else begin
      wordValid_q <= wordValid_d;
    end
  end

  assign word_valid = wordValid_q;
`else
  assign word_valid = resp;
`endif

endmodule

// File: tb/tb_line_fill_reader.sv
// Directed bench for line_fill_reader: a per-cycle vector table for reset/first fill, then
// hand-written sequences for stalls, back-to-back fills, mid-fill reset and word forwarding.
module tb_line_fill_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_read;
  logic [31:0]  req_addr;
  logic         resp;
  logic         word_valid;
  logic [31:0]  resp_rdata;
  logic [255:0] resp_line;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic         pmem_resp;
  logic [63:0]  pmem_rdata;

  int tests = 0;
  int fails = 0;

  localparam logic [63:0]  B0   = 64'h1111_1111_1111_1111;
  localparam logic [63:0]  B1   = 64'h2222_2222_2222_2222;
  localparam logic [63:0]  B2   = 64'h3333_3333_3333_3333;
  localparam logic [63:0]  B3   = 64'h4444_4444_4444_4444;
  localparam logic [63:0]  G1   = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0]  G2   = 64'h0123_4567_89AB_CDEF;
  localparam logic [255:0] FULL = {B3, B2, B1, B0};

`ifdef LFR_CRITICAL_WORD_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  line_fill_reader #(.BURST_WIDTH(64), .NUM_BURSTS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_read    (req_read),
    .req_addr    (req_addr),
    .resp        (resp),
    .word_valid  (word_valid),
    .resp_rdata  (resp_rdata),
    .resp_line   (resp_line),
    .pmem_read   (pmem_read),
    .pmem_address(pmem_address),
    .pmem_resp   (pmem_resp),
    .pmem_rdata  (pmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         reqRead;
    logic [31:0]  reqAddr;
    logic         pmemResp;
    logic [63:0]  pmemRdata;
    logic         expResp;
    logic         expWvBase;
    logic         expWvCrit;
    logic         expPmemRead;
    logic [31:0]  expPmemAddr;
    logic         chkData;
    logic [31:0]  expRdata;
    logic [255:0] expLine;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic r, input logic rr, input logic [31:0] a,
                              input logic pr, input logic [63:0] pd,
                              input logic eResp, input logic eWvB, input logic eWvC,
                              input logic ePr, input logic [31:0] eAddr, input logic chk,
                              input logic [31:0] eRd, input logic [255:0] eLine);
    vec_t v;
    v.rst = r; v.reqRead = rr; v.reqAddr = a; v.pmemResp = pr; v.pmemRdata = pd;
    v.expResp = eResp; v.expWvBase = eWvB; v.expWvCrit = eWvC; v.expPmemRead = ePr;
    v.expPmemAddr = eAddr; v.chkData = chk; v.expRdata = eRd; v.expLine = eLine;
    return v;
  endfunction

  function automatic logic [63:0] burstOf(input int k);
    case (k)
      0:       return B0;
      1:       return B1;
      2:       return B2;
      default: return B3;
    endcase
  endfunction

  task automatic checkVal(input string name, input logic [255:0] actual, input logic [255:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic eResp, input logic eWv, input logic ePr,
                             input logic [31:0] eAddr, input logic chk,
                             input logic [31:0] eRd, input logic [255:0] eLine);
    checkVal({tag, " resp"}, 256'(resp), 256'(eResp));
    checkVal({tag, " word_valid"}, 256'(word_valid), 256'(eWv));
    checkVal({tag, " pmem_read"}, 256'(pmem_read), 256'(ePr));
    checkVal({tag, " pmem_address"}, 256'(pmem_address), 256'(eAddr));
    if (chk) begin
      checkVal({tag, " resp_rdata"}, 256'(resp_rdata), 256'(eRd));
      checkVal({tag, " resp_line"}, resp_line, eLine);
    end
  endtask

  // Drives one cycle of inputs and returns at the following falling edge.
  task automatic applyStimulus(input logic r, input logic rr, input logic [31:0] a,
                               input logic pr, input logic [63:0] pd);
    rst        = r;
    req_read   = rr;
    req_addr   = a;
    pmem_resp  = pr;
    pmem_rdata = pd;
    @(negedge clk);
  endtask

  // Full fill starting from an IDLE cycle; stallAfter/stalls insert pmem_resp-low cycles before burst stallAfter.
  task automatic doRead(input string tag, input logic [31:0] addr, input int stallAfter,
                        input int stalls, input bit holdReq, input logic [31:0] expWord);
    int          bc[4];
    int          respCycle;
    int          wvCycle;
    int          expWv;
    logic        p;
    logic [63:0] d;
    respCycle = -1;
    wvCycle   = -1;
    for (int k = 0; k < 4; k++) bc[k] = 1 + k + ((k >= stallAfter) ? stalls : 0);
    expWv = CRIT ? bc[int'(addr[4:3])] + 1 : 5 + stalls;
    applyStimulus(1'b0, 1'b1, addr, 1'b0, 64'h0);
    for (int c = 1; c <= 20 && respCycle < 0; c++) begin
      if (word_valid && wvCycle < 0) wvCycle = c;
      if (c == 1) begin
        checkVal({tag, " pmem_read c1"}, 256'(pmem_read), 256'(1));
        checkVal({tag, " pmem_address c1"}, 256'(pmem_address), 256'({addr[31:5], 5'b0}));
        checkVal({tag, " line cleared c1"}, resp_line, 256'(0));
      end
      if (resp) begin
        respCycle = c;
        checkVal({tag, " resp_rdata"}, 256'(resp_rdata), 256'(expWord));
        checkVal({tag, " resp_line"}, resp_line, FULL);
      end
      p = 1'b0;
      d = 64'hA5A5_A5A5_A5A5_A5A5;
      for (int k = 0; k < 4; k++) begin
        if (bc[k] == c) begin
          p = 1'b1;
          d = burstOf(k);
        end
      end
      applyStimulus(1'b0, resp ? holdReq : 1'b1, resp ? addr : ~addr, p, d);
    end
    if (respCycle < 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s timeout: no resp within 20 cycles", tag);
    end else begin
      checkVal({tag, " resp cycle"}, 256'(respCycle), 256'(5 + stalls));
      checkVal({tag, " word_valid cycle"}, 256'(wvCycle), 256'(expWv));
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_read   = 1'b0;
    req_addr   = 32'h0;
    pmem_resp  = 1'b0;
    pmem_rdata = 64'h0;

    //                 rst   rr    addr          pr    data  resp  wvB   wvC   prd   paddr         chk   rdata         line
    vecs[0] = mk(1'b0, 1'b0, 32'h0,        1'b1, G1,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        256'h0);
    vecs[1] = mk(1'b0, 1'b0, 32'h0,        1'b1, G2,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        256'h0);
    vecs[2] = mk(1'b0, 1'b1, 32'h0000_1234, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        256'h0);
    vecs[3] = mk(1'b0, 1'b1, 32'hFFFF_FFE0, 1'b1, B0,   1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1220, 1'b1, 32'h0,        256'h0);
    vecs[4] = mk(1'b0, 1'b1, 32'hFFFF_FFE0, 1'b1, B1,   1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1220, 1'b1, 32'h0,        {192'h0, B0});
    vecs[5] = mk(1'b0, 1'b1, 32'hFFFF_FFE0, 1'b1, B2,   1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1220, 1'b1, 32'h0,        {128'h0, B1, B0});
    vecs[6] = mk(1'b0, 1'b1, 32'hFFFF_FFE0, 1'b1, B3,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1220, 1'b1, 32'h3333_3333, {64'h0, B2, B1, B0});
    vecs[7] = mk(1'b0, 1'b0, 32'h0,        1'b1, G1,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1220, 1'b1, 32'h3333_3333, FULL);
    vecs[8] = mk(1'b0, 1'b0, 32'h0,        1'b1, G2,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1220, 1'b1, 32'h3333_3333, FULL);
    vecs[9] = mk(1'b0, 1'b0, 32'h0,        1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1220, 1'b1, 32'h3333_3333, FULL);

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 256'h0);

    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("vec%0d", i), vecs[i].expResp,
                  CRIT ? vecs[i].expWvCrit : vecs[i].expWvBase,
                  vecs[i].expPmemRead, vecs[i].expPmemAddr, vecs[i].chkData,
                  vecs[i].expRdata, vecs[i].expLine);
      applyStimulus(vecs[i].rst, vecs[i].reqRead, vecs[i].reqAddr,
                    vecs[i].pmemResp, vecs[i].pmemRdata);
    end

    doRead("stall", 32'h0000_1234, 2, 2, 1'b0, 32'h3333_3333);
    doRead("b2b-a", 32'h0000_0040, 4, 0, 1'b1, 32'h1111_1111);
    doRead("b2b-b", 32'h0000_007C, 4, 0, 1'b0, 32'h4444_4444);

    // Reset lands after two bursts; the in-flight bursts that follow must be dropped.
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1, B0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1, B1);
    checkVal("rstmid pmem_read before rst", 256'(pmem_read), 256'(1));
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, B2);
    checkOutput("rstmid c1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 256'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, B3);
    checkOutput("rstmid c2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 256'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    checkOutput("rstmid c3", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 256'h0);

    doRead("after-rst", 32'h0000_0100, 4, 0, 1'b0, 32'h1111_1111);
    doRead("crit", 32'h0000_0008, 4, 0, 1'b0, 32'h2222_2222);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
